// File: rtl/mpu_pkg.sv
// Shared dimensions, index type and loader states for the MPU operand stage.
package mpu_pkg;

   localparam int MATRIX_N     = 5;
   localparam int ELEM_WIDTH   = 8;
   localparam int MATRIX_ELEMS = MATRIX_N * MATRIX_N;
   localparam int MATRIX_BITS  = MATRIX_ELEMS * ELEM_WIDTH;
   localparam int INDEX_WIDTH  = $clog2(MATRIX_ELEMS);

   typedef logic [INDEX_WIDTH-1:0] elem_index_t;

   localparam elem_index_t LAST_INDEX = elem_index_t'(MATRIX_ELEMS - 1);

   typedef enum logic [1:0] {
      LOAD_A,
      LOAD_B,
      FULL
   } loader_state_t;

endpackage

// File: rtl/mpu_matrix_bank.sv
// One N*N operand register array, written one element per cycle in row-major
// order and presented as a flat vector.
module mpu_matrix_bank
   import mpu_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   wr_en_i,
   input  elem_index_t            wr_index_i,
   input  logic [ELEM_WIDTH-1:0]  wr_data_i,
   output logic [MATRIX_BITS-1:0] matrix_o
);

   logic [MATRIX_BITS-1:0] matrix_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         matrix_q <= '0;
      end else if (wr_en_i) begin
         for (int e = 0; e < MATRIX_ELEMS; e++) begin
            if (wr_index_i == elem_index_t'(e)) begin
               matrix_q[e*ELEM_WIDTH +: ELEM_WIDTH] <= wr_data_i;
            end
         end
      end
   end

   assign matrix_o = matrix_q;

endmodule

// File: rtl/mpu_operand_loader.sv
// Fills operand A then B from a valid/ready byte stream and holds both stable
// for the element-wise stages until the consumer acknowledges them.
module mpu_operand_loader
   import mpu_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ELEM_WIDTH-1:0]  in_data,
   output logic                   operands_valid,
   input  logic                   operands_ack,
   output logic                   loading_b,
   output logic [MATRIX_BITS-1:0] matrix_a,
   output logic [MATRIX_BITS-1:0] matrix_b
);

   loader_state_t state_q;
   elem_index_t   index_q;
   elem_index_t   index_d;
   logic          in_ready_q;
   logic          loading_b_q;
   logic          operands_valid_q;
   logic          transfer;
   logic          wr_a;
   logic          wr_b;

   // A byte sent in the same cycle as clear is dropped, so clear gates the handshake.
   assign transfer = in_valid && in_ready_q && !clear;
   assign wr_a     = transfer && (state_q == LOAD_A);
   assign wr_b     = transfer && (state_q == LOAD_B);
   assign index_d  = index_q + elem_index_t'(1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= LOAD_A;
         index_q          <= '0;
         in_ready_q       <= 1'b1;
         loading_b_q      <= 1'b0;
         operands_valid_q <= 1'b0;
      end else if (clear) begin
         state_q          <= LOAD_A;
         index_q          <= '0;
         in_ready_q       <= 1'b1;
         loading_b_q      <= 1'b0;
         operands_valid_q <= 1'b0;
      end else begin
         case (state_q)
            LOAD_A: begin
               if (transfer) begin
                  if (index_q == LAST_INDEX) begin
                     state_q     <= LOAD_B;
                     index_q     <= '0;
                     loading_b_q <= 1'b1;
                  end else begin
                     index_q <= index_d;
                  end
               end
            end
            LOAD_B: begin
               if (transfer) begin
                  if (index_q == LAST_INDEX) begin
                     state_q          <= FULL;
                     index_q          <= '0;
                     in_ready_q       <= 1'b0;
                     loading_b_q      <= 1'b0;
                     operands_valid_q <= 1'b1;
                  end else begin
                     index_q <= index_d;
                  end
               end
            end
            FULL: begin
               if (operands_ack) begin
                  state_q          <= LOAD_A;
                  index_q          <= '0;
                  in_ready_q       <= 1'b1;
                  operands_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q          <= LOAD_A;
               index_q          <= '0;
               in_ready_q       <= 1'b1;
               loading_b_q      <= 1'b0;
               operands_valid_q <= 1'b0;
            end
         endcase
      end
   end

   mpu_matrix_bank u_bank_a (
      .clock      (clock),
      .reset_n    (reset_n),
      .wr_en_i    (wr_a),
      .wr_index_i (index_q),
      .wr_data_i  (in_data),
      .matrix_o   (matrix_a)
   );

   mpu_matrix_bank u_bank_b (
      .clock      (clock),
      .reset_n    (reset_n),
      .wr_en_i    (wr_b),
      .wr_index_i (index_q),
      .wr_data_i  (in_data),
      .matrix_o   (matrix_b)
   );

   assign in_ready       = in_ready_q;
   assign loading_b      = loading_b_q;
   assign operands_valid = operands_valid_q;

endmodule

// File: tb/tb_mpu_operand_loader.sv
// Scoreboarded bench for the MPU operand loader: a behavioural model tracks
// the expected A/B contents and every accepted byte is checked once loaded.
module tb_mpu_operand_loader;
   import mpu_pkg::*;

   logic                   clock = 1'b0;
   logic                   reset_n;
   logic                   clear;
   logic                   in_valid;
   logic                   in_ready;
   logic [ELEM_WIDTH-1:0]  in_data;
   logic                   operands_valid;
   logic                   operands_ack;
   logic                   loading_b;
   logic [MATRIX_BITS-1:0] matrix_a;
   logic [MATRIX_BITS-1:0] matrix_b;

   typedef struct {
      bit                    isB;
      int                    idx;
      logic [ELEM_WIDTH-1:0] val;
   } sbEntry_t;

   sbEntry_t              sb[$];
   int                    nCompared   = 0;
   int                    nMismatched = 0;
   int                    mState;
   int                    mIdx;
   logic [ELEM_WIDTH-1:0] mA[MATRIX_ELEMS];
   logic [ELEM_WIDTH-1:0] mB[MATRIX_ELEMS];

   mpu_operand_loader dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .clear          (clear),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .operands_valid (operands_valid),
      .operands_ack   (operands_ack),
      .loading_b      (loading_b),
      .matrix_a       (matrix_a),
      .matrix_b       (matrix_b)
   );

   always #5 clock = ~clock;

   // Model state: 0 = loading A, 1 = loading B, 2 = full.
   task automatic modelReset();
      mState = 0;
      mIdx   = 0;
      for (int i = 0; i < MATRIX_ELEMS; i++) begin
         mA[i] = '0;
         mB[i] = '0;
      end
      sb.delete();
   endtask

   function automatic logic [MATRIX_BITS-1:0] packModel(input bit selB);
      logic [MATRIX_BITS-1:0] r;
      for (int i = 0; i < MATRIX_ELEMS; i++)
         r[i*ELEM_WIDTH +: ELEM_WIDTH] = selB ? mB[i] : mA[i];
      return r;
   endfunction

   // Drives one clock of inputs from a negedge, advances the model at the
   // posedge and returns on the following negedge with inputs idle.
   task automatic applyStimulus(input bit v, input logic [ELEM_WIDTH-1:0] d,
                                input bit ack, input bit clr);
      in_valid     = v;
      in_data      = d;
      operands_ack = ack;
      clear        = clr;
      @(posedge clock);
      if (clr) begin
         mState = 0;
         mIdx   = 0;
         sb.delete();
      end else if (mState < 2) begin
         if (v) begin
            if (mState == 0) mA[mIdx] = d;
            else             mB[mIdx] = d;
            sb.push_back('{isB: (mState == 1), idx: mIdx, val: d});
            if (mIdx == MATRIX_ELEMS - 1) begin
               mIdx   = 0;
               mState = mState + 1;
            end else begin
               mIdx = mIdx + 1;
            end
         end
      end else if (ack) begin
         mState = 0;
         mIdx   = 0;
      end
      @(negedge clock);
      in_valid     = 1'b0;
      operands_ack = 1'b0;
      clear        = 1'b0;
   endtask

   task automatic test_reset();
      nCompared++;
      if (in_ready !== 1'b1 || operands_valid !== 1'b0 || loading_b !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_flags: got rdy=%b vld=%b lb=%b expected 1 0 0",
                  in_ready, operands_valid, loading_b);
      end
      for (int k = 0; k < 30; k++) applyStimulus(1'b1, 8'(k + 1), 1'b0, 1'b0);
      nCompared++;
      if (loading_b !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL pre_reset_lb: got %b expected 1", loading_b);
      end
      #2 reset_n = 1'b0;
      #1;
      modelReset();
      nCompared++;
      if (in_ready !== 1'b1 || operands_valid !== 1'b0 || loading_b !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL midreset_flags: got rdy=%b vld=%b lb=%b expected 1 0 0",
                  in_ready, operands_valid, loading_b);
      end
      nCompared++;
      if (matrix_a !== '0 || matrix_b !== '0) begin
         nMismatched++;
         $display("[TB] FAIL midreset_matrix: got a=%0h b=%0h expected 0 0", matrix_a, matrix_b);
      end
      #1 reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_full_load();
      sbEntry_t              e;
      logic [ELEM_WIDTH-1:0] got;
      for (int k = 0; k < 50; k++) begin
         applyStimulus(1'b1, (k < 25) ? 8'(k + 1) : 8'(101 + k - 25), 1'b0, 1'b0);
         if (k == 24) begin
            nCompared++;
            if (loading_b !== 1'b1) begin
               nMismatched++;
               $display("[TB] FAIL full_lb_after25: got %b expected 1", loading_b);
            end
         end
         if (k == 48) begin
            nCompared++;
            if (operands_valid !== 1'b0) begin
               nMismatched++;
               $display("[TB] FAIL full_vld_at49: got %b expected 0", operands_valid);
            end
         end
      end
      nCompared++;
      if (operands_valid !== 1'b1 || in_ready !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL full_vld_at50: got vld=%b rdy=%b expected 1 0", operands_valid, in_ready);
      end
      nCompared++;
      if (matrix_a[7:0] !== 8'd1 || matrix_a[24*8 +: 8] !== 8'd25) begin
         nMismatched++;
         $display("[TB] FAIL full_a_corners: got %0d %0d expected 1 25",
                  matrix_a[7:0], matrix_a[24*8 +: 8]);
      end
      nCompared++;
      if (matrix_b[7:0] !== 8'd101 || matrix_b[24*8 +: 8] !== 8'd125) begin
         nMismatched++;
         $display("[TB] FAIL full_b_corners: got %0d %0d expected 101 125",
                  matrix_b[7:0], matrix_b[24*8 +: 8]);
      end
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         got = e.isB ? matrix_b[e.idx*ELEM_WIDTH +: ELEM_WIDTH] : matrix_a[e.idx*ELEM_WIDTH +: ELEM_WIDTH];
         nCompared++;
         if (got !== e.val) begin
            nMismatched++;
            $display("[TB] FAIL full_sb %s[%0d]: got %0h expected %0h", e.isB ? "B" : "A", e.idx, got, e.val);
         end
      end
   endtask

   task automatic test_hold_ack();
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
         nCompared++;
         if (in_ready !== 1'b0 || operands_valid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL hold_flags c%0d: got rdy=%b vld=%b expected 0 1", c, in_ready, operands_valid);
         end
      end
      nCompared++;
      if (matrix_a !== packModel(1'b0) || matrix_b !== packModel(1'b1)) begin
         nMismatched++;
         $display("[TB] FAIL hold_frozen: got a=%0h b=%0h expected a=%0h b=%0h",
                  matrix_a, matrix_b, packModel(1'b0), packModel(1'b1));
      end
      applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
      nCompared++;
      if (in_ready !== 1'b1 || operands_valid !== 1'b0 || matrix_a !== packModel(1'b0)) begin
         nMismatched++;
         $display("[TB] FAIL ack_rearm: got rdy=%b vld=%b a=%0h expected 1 0 %0h",
                  in_ready, operands_valid, matrix_a, packModel(1'b0));
      end
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
      nCompared++;
      if (matrix_a[7:0] !== 8'h55 || matrix_a[15:8] !== 8'd2) begin
         nMismatched++;
         $display("[TB] FAIL ack_first_byte: got %0h %0h expected 55 2", matrix_a[7:0], matrix_a[15:8]);
      end
   endtask

   task automatic test_ack_ignored();
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
      nCompared++;
      if (matrix_a[15:8] !== 8'h66 || in_ready !== 1'b1 || loading_b !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL ack_outside_full: got a1=%0h rdy=%b lb=%b expected 66 1 0",
                  matrix_a[15:8], in_ready, loading_b);
      end
   endtask

   task automatic test_gappy();
      sbEntry_t              e;
      logic [ELEM_WIDTH-1:0] got;
      int                    sent = 0;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      for (int c = 0; c < 100; c++) begin
         applyStimulus((c % 2) == 0, 8'(c * 3 + 7), 1'b0, 1'b0);
         if ((c % 2) == 0) sent++;
         nCompared++;
         if (loading_b !== (sent >= 25 && sent < 50)) begin
            nMismatched++;
            $display("[TB] FAIL gappy_lb c%0d sent%0d: got %b expected %b", c, sent, loading_b,
                     (sent >= 25 && sent < 50));
         end
      end
      nCompared++;
      if (operands_valid !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL gappy_vld: got %b expected 1", operands_valid);
      end
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         got = e.isB ? matrix_b[e.idx*ELEM_WIDTH +: ELEM_WIDTH] : matrix_a[e.idx*ELEM_WIDTH +: ELEM_WIDTH];
         nCompared++;
         if (got !== e.val) begin
            nMismatched++;
            $display("[TB] FAIL gappy_sb %s[%0d]: got %0h expected %0h", e.isB ? "B" : "A", e.idx, got, e.val);
         end
      end
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic test_clear();
      for (int k = 0; k < 30; k++) applyStimulus(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
      nCompared++;
      if (loading_b !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL clear_pre_lb: got %b expected 1", loading_b);
      end
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
      nCompared++;
      if (loading_b !== 1'b0 || in_ready !== 1'b1 || operands_valid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL clear_flags: got lb=%b rdy=%b vld=%b expected 0 1 0",
                  loading_b, in_ready, operands_valid);
      end
      nCompared++;
      if (matrix_a !== packModel(1'b0) || matrix_b !== packModel(1'b1)) begin
         nMismatched++;
         $display("[TB] FAIL clear_retain: got a=%0h b=%0h expected a=%0h b=%0h",
                  matrix_a, matrix_b, packModel(1'b0), packModel(1'b1));
      end
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
      nCompared++;
      if (matrix_a[7:0] !== 8'h33 || matrix_a[15:8] !== 8'h41) begin
         nMismatched++;
         $display("[TB] FAIL clear_restart: got %0h %0h expected 33 41", matrix_a[7:0], matrix_a[15:8]);
      end
   endtask

   task automatic test_back_to_back();
      sbEntry_t              e;
      logic [ELEM_WIDTH-1:0] got;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 50; k++) begin
            applyStimulus(1'b1, (s == 0) ? 8'(8'h80 + k) : 8'(8'h7F - k), 1'b0, 1'b0);
            if (k == 48) begin
               nCompared++;
               if (operands_valid !== 1'b0) begin
                  nMismatched++;
                  $display("[TB] FAIL b2b_vld_early set%0d: got %b expected 0", s, operands_valid);
               end
            end
         end
         nCompared++;
         if (operands_valid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL b2b_vld set%0d: got %b expected 1", s, operands_valid);
         end
         while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = e.isB ? matrix_b[e.idx*ELEM_WIDTH +: ELEM_WIDTH] : matrix_a[e.idx*ELEM_WIDTH +: ELEM_WIDTH];
            nCompared++;
            if (got !== e.val) begin
               nMismatched++;
               $display("[TB] FAIL b2b_sb set%0d %s[%0d]: got %0h expected %0h", s, e.isB ? "B" : "A",
                        e.idx, got, e.val);
            end
         end
         nCompared++;
         if (matrix_a !== packModel(1'b0) || matrix_b !== packModel(1'b1)) begin
            nMismatched++;
            $display("[TB] FAIL b2b_whole set%0d: got a=%0h b=%0h", s, matrix_a, matrix_b);
         end
         if (s == 0) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      nCompared++;
      if (operands_valid !== 1'b0 || in_ready !== 1'b1 || matrix_a !== packModel(1'b0)) begin
         nMismatched++;
         $display("[TB] FAIL clear_in_full: got vld=%b rdy=%b expected 0 1, a retained=%b",
                  operands_valid, in_ready, matrix_a === packModel(1'b0));
      end
   endtask

   initial begin
      reset_n      = 1'b0;
      clear        = 1'b0;
      in_valid     = 1'b0;
      in_data      = '0;
      operands_ack = 1'b0;
      modelReset();
      #12 reset_n = 1'b1;
      @(negedge clock);
      $display("[TB] starting operand loader tests");
      test_reset();
      test_full_load();
      test_hold_ack();
      test_ack_ignored();
      test_gappy();
      test_clear();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
